serial_add_ctrl: RTL and testbench

//   Bit-serial add sequencer: adds two WIDTH-bit operands plus carry-in using one

---
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving one external full-adder slice, LSB first,
// with valid/ready handshakes on the command and result sides.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  // New sum bit enters at the MSB so the LSB-first result lands aligned.
  generate
    if (WIDTH == 1) begin : g_one
      assign sum_next = fa_s;
    end else begin : g_wide
      assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  assign fa_a = (state == RUN) & a_sr[0];
  assign fa_b = (state == RUN) & b_sr[0];
  assign fa_c = (state == RUN) & carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum         <= '0;
      cout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr        <= op_a;
            b_sr        <= op_b;
            carry       <= cin;
            sum_sr      <= '0;
            cnt         <= '0;
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= fa_carry;
          cnt    <= cnt + 1'b1;
          // Result registers only change here, so they stay put through RUN and IDLE.
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            res_valid <= 1'b1;
            sum       <= sum_next;
            cout      <= fa_carry;
          end
        end
        DONE: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, each with a
// combinational full-adder slice, checked against hand-computed vectors.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready, cin, busy;
  logic [7:0] op_a, op_b, sum;
  logic       fa_a, fa_b, fa_c, fa_s, fa_carry;
  logic       res_valid, res_ready, cout;

  logic s1_start_valid, s1_start_ready, s1_cin, s1_busy;
  logic s1_op_a, s1_op_b, s1_sum, s1_cout;
  logic s1_fa_a, s1_fa_b, s1_fa_c, s1_fa_s, s1_fa_carry;
  logic s1_res_valid, s1_res_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign fa_s        = fa_a ^ fa_b ^ fa_c;
  assign fa_carry    = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  assign s1_fa_s     = s1_fa_a ^ s1_fa_b ^ s1_fa_c;
  assign s1_fa_carry = (s1_fa_a & s1_fa_b) | (s1_fa_a & s1_fa_c) | (s1_fa_b & s1_fa_c);

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .busy(busy),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_carry(fa_carry),
    .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start_valid(s1_start_valid), .start_ready(s1_start_ready),
    .op_a(s1_op_a), .op_b(s1_op_b), .cin(s1_cin), .busy(s1_busy),
    .fa_a(s1_fa_a), .fa_b(s1_fa_b), .fa_c(s1_fa_c), .fa_s(s1_fa_s), .fa_carry(s1_fa_carry),
    .res_valid(s1_res_valid), .res_ready(s1_res_ready), .sum(s1_sum), .cout(s1_cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction from a negedge in IDLE; returns result and accept-to-valid latency.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               output logic [7:0] s, output logic co, output int lat);
    int guard = 0;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    cin  = c;
    while (!start_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_wait", 32'(guard < 20), 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    cin  = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s  = sum;
    co = cout;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] got_s;
    logic       got_c;
    int         lat;
    logic [8:0] exp9;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};

    rst_n = 1'b0;
    start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; res_ready = 1'b0;
    s1_start_valid = 1'b0; s1_op_a = 1'b0; s1_op_b = 1'b0; s1_cin = 1'b0; s1_res_ready = 1'b0;
    #12;
    checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    checkOutput("rst_w1_start_ready", 32'(s1_start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, got_s, got_c, lat);
      checkOutput($sformatf("vec%0d_sum", i), 32'(got_s), 32'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d_cout", i), 32'(got_c), 32'(vecs[i].exp_cout));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
    end

    $display("[TB] stall in DONE with stray commands");
    start_valid = 1'b1; op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0;
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22;
    checkOutput("stall_busy_run", 32'(busy), 32'd1);
    checkOutput("stall_start_ready_run", 32'(start_ready), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("stall_valid_rise", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", i), 32'(res_valid), 32'd1);
      checkOutput($sformatf("stall%0d_sum", i), 32'(sum), 32'h96);
      checkOutput($sformatf("stall%0d_cout", i), 32'(cout), 32'd0);
      checkOutput($sformatf("stall%0d_start_ready", i), 32'(start_ready), 32'd0);
      checkOutput($sformatf("stall%0d_fa", i), 32'({fa_a, fa_b, fa_c}), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("stall_release_valid", 32'(res_valid), 32'd0);
    checkOutput("stall_release_start_ready", 32'(start_ready), 32'd1);
    checkOutput("stall_idle_sum_kept", 32'(sum), 32'h96);
    @(negedge clk);
    checkOutput("stall_no_stray_accept", 32'(busy), 32'd0);

    $display("[TB] reset during RUN");
    start_valid = 1'b1; op_a = 8'hFF; op_b = 8'h00; cin = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    checkOutput("abort_fa_a_before", 32'(fa_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    checkOutput("abort_start_ready", 32'(start_ready), 32'd1);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h0F, 8'h01, 1'b0, got_s, got_c, lat);
    checkOutput("post_abort_sum", 32'(got_s), 32'h10);
    checkOutput("post_abort_cout", 32'(got_c), 32'd0);
    checkOutput("post_abort_latency", 32'(lat), 32'd8);

    $display("[TB] WIDTH=1 instance");
    s1_start_valid = 1'b1; s1_op_a = 1'b1; s1_op_b = 1'b1; s1_cin = 1'b1;
    @(negedge clk);
    s1_start_valid = 1'b0; s1_op_a = 1'b0; s1_op_b = 1'b0; s1_cin = 1'b0;
    checkOutput("w1_fa_active", 32'({s1_fa_a, s1_fa_b, s1_fa_c}), 32'd7);
    @(negedge clk);
    checkOutput("w1_valid", 32'(s1_res_valid), 32'd1);
    checkOutput("w1_sum", 32'(s1_sum), 32'd1);
    checkOutput("w1_cout", 32'(s1_cout), 32'd1);
    s1_res_ready = 1'b1;
    @(negedge clk);
    s1_res_ready = 1'b0;
    checkOutput("w1_start_ready", 32'(s1_start_ready), 32'd1);
    s1_start_valid = 1'b1; s1_op_a = 1'b1; s1_op_b = 1'b0; s1_cin = 1'b0;
    @(negedge clk);
    s1_start_valid = 1'b0;
    @(negedge clk);
    checkOutput("w1b_valid", 32'(s1_res_valid), 32'd1);
    checkOutput("w1b_sum", 32'(s1_sum), 32'd1);
    checkOutput("w1b_cout", 32'(s1_cout), 32'd0);
    s1_res_ready = 1'b1;
    @(negedge clk);
    s1_res_ready = 1'b0;

    $display("[TB] random back-to-back adds");
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      applyStimulus(ra, rb, rc, got_s, got_c, lat);
      checkOutput($sformatf("rand%0d_result", i), 32'({got_c, got_s}), 32'(exp9));
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'd8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
